// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision FP adder datapath.
// Operands are unpacked into {sign, effective exponent, mantissa with hidden bit}.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = FRAC_W + 1;
  localparam int OP_W    = 1 + EXP_W + FRAC_W;
  localparam int BIAS    = 127;
  localparam int SHIFT_W = $clog2(MANT_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_SWAP   = 3'd2,
    ST_ALIGN  = 3'd3,
    ST_ADD    = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } op_t;

  // Denormals get exponent 1 and no hidden bit, so they align like normals.
  function automatic op_t unpack(input logic [OP_W-1:0] raw);
    op_t op;
    op.sign = raw[OP_W-1];
    op.exp  = (raw[OP_W-2 -: EXP_W] == '0) ? EXP_W'(1) : raw[OP_W-2 -: EXP_W];
    op.mant = {|raw[OP_W-2 -: EXP_W], raw[FRAC_W-1:0]};
    return op;
  endfunction

endpackage

// File: rtl/operand_swap.sv
// Orders two unpacked operands by magnitude (A wins ties) and computes the
// clamped alignment distance for the smaller one.
module operand_swap
  import fp_pkg::*;
#(
  parameter int MAX_SHIFT = MANT_W
) (
  input  op_t                op_a,
  input  op_t                op_b,
  output op_t                big_op,
  output logic [MANT_W-1:0]  sml_mant,
  output logic [SHIFT_W-1:0] shift
);

  logic             a_is_big;
  logic [EXP_W-1:0] sml_exp;
  logic [EXP_W-1:0] diff;

  always_comb begin
    a_is_big = {op_a.exp, op_a.mant} >= {op_b.exp, op_b.mant};
    big_op   = a_is_big ? op_a : op_b;
    sml_mant = a_is_big ? op_b.mant : op_a.mant;
    sml_exp  = a_is_big ? op_b.exp : op_a.exp;
    diff     = big_op.exp - sml_exp;
    shift    = (diff > EXP_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : diff[SHIFT_W-1:0];
  end

endmodule

// File: rtl/align_add_unit.sv
// Front half of the FP adder: unpack, order by magnitude, align the smaller
// mantissa one bit per cycle, then add or subtract. Feeds normalizing_unit.
module align_add_unit #(
  parameter int EXP_W     = fp_pkg::EXP_W,
  parameter int FRAC_W    = fp_pkg::FRAC_W,
  parameter int MAX_SHIFT = fp_pkg::MANT_W
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    enable,
  input  logic [EXP_W+FRAC_W:0]   operand_a,
  input  logic [EXP_W+FRAC_W:0]   operand_b,
  output logic                    carry,
  output logic [FRAC_W:0]         mantissa,
  output logic [EXP_W-1:0]        exponent,
  output logic                    sign,
  output logic                    done
);

  import fp_pkg::*;

  state_e              state_q, state_d;
  op_t                 a_q, a_d, b_q, b_d, big_q, big_d;
  logic [MANT_W-1:0]   sml_mant_q, sml_mant_d;
  logic [SHIFT_W-1:0]  cnt_q, cnt_d;
  logic                sub_q, sub_d;
  logic                carry_q, carry_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic                sign_q, sign_d;
  logic                done_q, done_d;

  op_t                 swap_big;
  logic [MANT_W-1:0]   swap_sml_mant;
  logic [SHIFT_W-1:0]  swap_shift;
  logic [MANT_W:0]     sum;

  operand_swap #(.MAX_SHIFT(MAX_SHIFT)) u_swap (
    .op_a     (a_q),
    .op_b     (b_q),
    .big_op   (swap_big),
    .sml_mant (swap_sml_mant),
    .shift    (swap_shift)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    big_d      = big_q;
    sml_mant_d = sml_mant_q;
    cnt_d      = cnt_q;
    sub_d      = sub_q;
    carry_d    = carry_q;
    mant_d     = mant_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    done_d     = done_q;
    sum        = '0;

    // Dropping enable anywhere aborts; data outputs keep their last values.
    if (state_q != ST_IDLE && !enable) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_d = 1'b0;
          if (enable) state_d = ST_UNPACK;
        end
        ST_UNPACK: begin
          a_d     = unpack(operand_a);
          b_d     = unpack(operand_b);
          state_d = ST_SWAP;
        end
        ST_SWAP: begin
          big_d      = swap_big;
          sml_mant_d = swap_sml_mant;
          cnt_d      = swap_shift;
          sub_d      = a_q.sign ^ b_q.sign;
          state_d    = ST_ALIGN;
        end
        ST_ALIGN: begin
          if (cnt_q != '0) begin
            sml_mant_d = sml_mant_q >> 1;
            cnt_d      = cnt_q - 1'b1;
          end else begin
            state_d = ST_ADD;
          end
        end
        ST_ADD: begin
          if (sub_q) begin
            sum     = {1'b0, big_q.mant} - {1'b0, sml_mant_q};
            carry_d = 1'b0;
            sign_d  = (sum == '0) ? 1'b0 : big_q.sign;
          end else begin
            sum     = {1'b0, big_q.mant} + {1'b0, sml_mant_q};
            carry_d = sum[MANT_W];
            sign_d  = big_q.sign;
          end
          mant_d  = sum[MANT_W-1:0];
          exp_d   = big_q.exp;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: all state, including the operand holding registers, is cleared by the
  // async reset, and sequential blocks use non-blocking assignments only.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      big_q      <= '0;
      sml_mant_q <= '0;
      cnt_q      <= '0;
      sub_q      <= 1'b0;
      carry_q    <= 1'b0;
      mant_q     <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      big_q      <= big_d;
      sml_mant_q <= sml_mant_d;
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      carry_q    <= carry_d;
      mant_q     <= mant_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      done_q     <= done_d;
    end
  end

  assign carry    = carry_q;
  assign mantissa = mant_q;
  assign exponent = exp_q;
  assign sign     = sign_q;
  assign done     = done_q;

endmodule

// File: tb/tb_align_add_unit.sv
// Self-checking bench for align_add_unit: vector table plus scoreboard queue,
// with hand-written reset, abort and operand-hold sequences.
module tb_align_add_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        enable;
  logic [31:0] operand_a, operand_b;
  logic        carry;
  logic [23:0] mantissa;
  logic [7:0]  exponent;
  logic        sign, done;

  align_add_unit dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .enable    (enable),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .carry     (carry),
    .mantissa  (mantissa),
    .exponent  (exponent),
    .sign      (sign),
    .done      (done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [23:0] m;
    logic [7:0]  e;
    logic        s;
    int          lat;   // edge index of done, sampling edge counted as 0
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  task automatic drive(input vec_t v);
    @(negedge Clk);
    operand_a = v.a;
    operand_b = v.b;
    enable    = 1'b1;
    sb.push_back(v);
  endtask

  // Waits for done, compares against the scoreboard head, checks hold, releases.
  task automatic collect(input string tag, input int pre_edges);
    vec_t ev;
    int   edges;
    bit   seen;
    edges = pre_edges;
    seen  = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge Clk);
      #1;
      edges++;
      if (done) seen = 1'b1;
    end
    ev = sb.pop_front();
    if (!seen) begin
      check({tag, " done timeout"}, 32'(done), 32'd1);
    end else begin
      check({tag, " carry"},    32'(carry),    32'(ev.c));
      check({tag, " mantissa"}, 32'(mantissa), 32'(ev.m));
      check({tag, " exponent"}, 32'(exponent), 32'(ev.e));
      check({tag, " sign"},     32'(sign),     32'(ev.s));
      check({tag, " latency"},  32'(edges - 1), 32'(ev.lat));
      repeat (2) @(posedge Clk);
      #1;
      check({tag, " hold done"},     32'(done),     32'd1);
      check({tag, " hold mantissa"}, 32'(mantissa), 32'(ev.m));
    end
    @(negedge Clk);
    enable = 1'b0;
    @(posedge Clk);
    #1;
    check({tag, " release done"}, 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 24'hC00000, 8'd128, 1'b0, 5};
    vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 24'h800000, 8'd127, 1'b0, 4};
    vecs[2]  = '{32'h3F800000, 32'hBF800000, 1'b0, 24'h000000, 8'd127, 1'b0, 4};
    vecs[3]  = '{32'h40000000, 32'hBFC00000, 1'b0, 24'h200000, 8'd128, 1'b0, 5};
    vecs[4]  = '{32'h3F800000, 32'hC0000000, 1'b0, 24'h400000, 8'd128, 1'b1, 5};
    vecs[5]  = '{32'h4B800000, 32'h3F800000, 1'b0, 24'h800000, 8'd151, 1'b0, 28};
    vecs[6]  = '{32'h53800000, 32'h3F800000, 1'b0, 24'h800000, 8'd167, 1'b0, 28};
    vecs[7]  = '{32'h4B000000, 32'h3F800000, 1'b0, 24'h800001, 8'd150, 1'b0, 27};
    vecs[8]  = '{32'h00000000, 32'h00000000, 1'b0, 24'h000000, 8'd1,   1'b0, 4};
    vecs[9]  = '{32'h00400000, 32'h00800000, 1'b0, 24'hC00000, 8'd1,   1'b0, 4};
    vecs[10] = '{32'hC0400000, 32'hBF800000, 1'b1, 24'h000000, 8'd128, 1'b1, 5};
    vecs[11] = '{32'h3F800000, 32'hBFC00000, 1'b0, 24'h400000, 8'd127, 1'b1, 4};
    vecs[12] = '{32'h7F800000, 32'h7F800000, 1'b1, 24'h000000, 8'd255, 1'b0, 4};

    Reset     = 1'b1;
    enable    = 1'b0;
    operand_a = '0;
    operand_b = '0;
    #12;
    check("reset done",     32'(done),     32'd0);
    check("reset carry",    32'(carry),    32'd0);
    check("reset mantissa", 32'(mantissa), 32'd0);
    check("reset exponent", 32'(exponent), 32'd0);
    check("reset sign",     32'(sign),     32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      collect($sformatf("vec%0d", i), 0);
    end

    // Operands change after the latch edge; the result must not follow them.
    drive(vecs[3]);
    repeat (2) @(posedge Clk);
    #1;
    operand_a = 32'hFFFFFFFF;
    operand_b = 32'h00000000;
    collect("operand hold", 2);

    // Abort mid-ALIGN: done never rises and data keeps vecs[3]'s result.
    @(negedge Clk);
    operand_a = vecs[5].a;
    operand_b = vecs[5].b;
    enable    = 1'b1;
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    enable = 1'b0;
    @(posedge Clk);
    #1;
    check("abort done",     32'(done),     32'd0);
    check("abort mantissa", 32'(mantissa), 32'(vecs[3].m));
    check("abort exponent", 32'(exponent), 32'(vecs[3].e));
    repeat (3) @(posedge Clk);
    #1;
    check("abort idle done", 32'(done), 32'd0);

    drive(vecs[0]);
    collect("re-enable", 0);

    // Asynchronous reset mid-ALIGN clears outputs without a clock edge.
    @(negedge Clk);
    operand_a = vecs[5].a;
    operand_b = vecs[5].b;
    enable    = 1'b1;
    repeat (8) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("async rst mantissa", 32'(mantissa), 32'd0);
    check("async rst exponent", 32'(exponent), 32'd0);
    check("async rst carry",    32'(carry),    32'd0);
    check("async rst sign",     32'(sign),     32'd0);
    check("async rst done",     32'(done),     32'd0);
    @(negedge Clk);
    Reset  = 1'b0;
    enable = 1'b0;

    drive(vecs[1]);
    collect("after reset", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
